// File: rtl/regfile_2r1w.sv
// Register file with one byte-enabled write port and two registered read ports.
// The array is cleared by an init sweep after reset. Define REGFILE_BYPASS_EN to forward same-edge writes to reads.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweep writes RESET_VAL to every entry; requests ignored
// ST_RUN  | normal operation: byte-enabled writes, two read ports
module regfile_2r1w #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 3,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  nreset,
    output logic                  init_busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en_a,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic                  rd_vld_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  rd_vld_b
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NBYTE = DATA_W/8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic [ADDR_W-1:0]   w_init_cnt_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_run;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0]   w_wr_merged;
    logic [DATA_W-1:0]   w_rd_word_a;
    logic [DATA_W-1:0]   w_rd_word_b;

    logic [DATA_W-1:0]   r_rd_data_a;
    logic [DATA_W-1:0]   r_rd_data_b;
    logic                r_rd_vld_a;
    logic                r_rd_vld_b;

    // Write word: new bytes where enabled, current contents elsewhere.
    always_comb begin
        w_wr_merged = r_mem[wr_addr];
        for (int i = 0; i < NBYTE; i++) begin
            if (wr_be[i]) begin
                w_wr_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_run          = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr     = wr_addr;
        w_mem_wdata    = w_wr_merged;
        case (r_state)
            ST_INIT: begin
                w_mem_we       = 1'b1;
                w_mem_addr     = r_init_cnt;
                w_mem_wdata    = RESET_VAL;
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (&r_init_cnt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run    = 1'b1;
                w_mem_we = wr_en;
            end
            default: begin
                w_state_nxt    = ST_INIT;
                w_init_cnt_nxt = '0;
            end
        endcase
    end

    assign init_busy = (r_state == ST_INIT);

    // The array has no reset; the init sweep is what clears it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_comb begin
        w_rd_word_a = r_mem[rd_addr_a];
        w_rd_word_b = r_mem[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr_a)) begin
            w_rd_word_a = w_wr_merged;
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            w_rd_word_b = w_wr_merged;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            r_rd_vld_a  <= 1'b0;
            r_rd_vld_b  <= 1'b0;
        end else if (w_run) begin
            r_rd_vld_a <= rd_en_a;
            r_rd_vld_b <= rd_en_b;
            if (rd_en_a) begin
                r_rd_data_a <= w_rd_word_a;
            end
            if (rd_en_b) begin
                r_rd_data_b <= w_rd_word_b;
            end
        end else begin
            r_rd_vld_a <= 1'b0;
            r_rd_vld_b <= 1'b0;
        end
    end

    assign rd_data_a = r_rd_data_a;
    assign rd_data_b = r_rd_data_b;
    assign rd_vld_a  = r_rd_vld_a;
    assign rd_vld_b  = r_rd_vld_b;

endmodule
